// File: rtl/datapath_bus_pkg.sv
// datapath_bus_pkg
//   Shared encodings for the datapath responder: bus source codes carried on
//   read_en, bit positions inside write_en/inc_en/clr_en, ALU operation codes
//   and the default widths.
//   Configuration macro DP_ALU_MULT_EN (used by datapath_alu) enables the
//   multiplier behind ALU_MULT.
package datapath_bus_pkg;

  localparam int DW_DEF = 16;
  localparam int IW_DEF = 6;

  // read_en: which register drives the shared bus
  typedef enum logic [3:0] {
    SRC_NONE = 4'd0,
    SRC_PC   = 4'd1,
    SRC_AR   = 4'd2,
    SRC_IR   = 4'd4,
    SRC_AC   = 4'd5,
    SRC_R    = 4'd6,
    SRC_R1   = 4'd7,
    SRC_R2   = 4'd8,
    SRC_R3   = 4'd9,
    SRC_R4   = 4'd10,
    SRC_DM   = 4'd12,
    SRC_IM   = 4'd13
  } src_e;

  // write_en / inc_en / clr_en bit positions
  localparam int WB_PC     = 1;
  localparam int WB_AR     = 2;
  localparam int WB_IR     = 3;
  localparam int WB_AC     = 4;
  localparam int WB_R      = 5;
  localparam int WB_R4     = 7;
  localparam int WB_R3     = 8;
  localparam int WB_R2     = 9;
  localparam int WB_R1     = 10;
  localparam int WB_DM     = 11;
  localparam int WB_AC_ALU = 12;

  typedef enum logic [2:0] {
    ALU_NONE   = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_MULT   = 3'd3,
    ALU_LSHIFT = 3'd4
  } alu_op_e;

endpackage

// File: rtl/datapath_alu.sv
// datapath_alu
//   Combinational ALU, A = AC, B = R, all results modulo 2^DW.
//   Ports:
//     i_a   in  DW  operand A (AC)
//     i_b   in  DW  operand B (R)
//     i_op  in  3   operation code (alu_op_e)
//     o_y   out DW  result
//   Configuration: DP_ALU_MULT_EN defined -> ALU_MULT returns low DW bits of
//   A*B; undefined -> no multiplier, ALU_MULT passes A through.
module datapath_alu
  import datapath_bus_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [2:0]    i_op,
  output logic [DW-1:0] o_y
);

  logic [DW-1:0] w_mult;

`ifdef DP_ALU_MULT_EN
  // DW x DW operands in a DW-wide context keep only the low half
  assign w_mult = i_a * i_b;
`else
  // Pass-through makes an AC write-back of a multiply a no-op
  assign w_mult = i_a;
  logic w_unused_b;
  assign w_unused_b = ^i_b;
`endif

  always_comb begin
    o_y = i_a;
    case (alu_op_e'(i_op))
      ALU_ADD:    o_y = i_a + i_b;
      ALU_SUB:    o_y = i_a - i_b;
      ALU_MULT:   o_y = w_mult;
      ALU_LSHIFT: o_y = {i_a[DW-2:0], 1'b0};
      default:    o_y = i_a;
    endcase
  end

endmodule

// File: rtl/datapath_bus.sv
// datapath_bus
//   Datapath responder to the microcoded control FSM. Owns the shared bus,
//   PC/AR/IR/AC/R/R1-R4, a bus latch for split read/write transfers, the ALU
//   and the DM write strobe.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     read_en     in 4  bus source select (src_e); unmapped codes drive 0
//     write_en    in 16 per-register write, bit 11 DM store, bit 12 AC<-ALU
//     inc_en      in 16 per-register increment (bits 1-10)
//     clr_en      in 16 per-register clear (bits 1-10)
//     alu_op      in 3  ALU operation
//     im_addr     out   PC;      im_rdata in  instruction memory data
//     dm_addr     out   AR;      dm_rdata in  data memory data
//     dm_wdata    out   AC captured with the store strobe
//     dm_we       out   one-cycle registered DM write strobe
//     instruction out   IR[IW-1:0]
//     z           out   {15'b0, AC==0}
//   Configuration: DP_ALU_MULT_EN (see datapath_alu).
module datapath_bus
  import datapath_bus_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    read_en,
  input  logic [15:0]   write_en,
  input  logic [15:0]   inc_en,
  input  logic [15:0]   clr_en,
  input  logic [2:0]    alu_op,
  output logic [DW-1:0] im_addr,
  input  logic [DW-1:0] im_rdata,
  output logic [DW-1:0] dm_addr,
  input  logic [DW-1:0] dm_rdata,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_we,
  output logic [IW-1:0] instruction,
  output logic [15:0]   z
);

  logic [DW-1:0] r_pc, r_ar, r_ir, r_ac, r_r;
  logic [DW-1:0] r_r1, r_r2, r_r3, r_r4;
  logic [DW-1:0] r_bus_latch;
  logic [DW-1:0] r_dm_wdata;
  logic          r_dm_we;

  logic [DW-1:0] w_bus;
  logic [DW-1:0] w_wd;
  logic [DW-1:0] w_alu_y;
  logic [DW-1:0] w_ac_wd;
  logic          w_bus_active;

  // Bits with no destination; gathered so they are visibly consumed
  logic w_unused_bits;
  assign w_unused_bits = ^{write_en[0], write_en[6], write_en[15:13],
                           inc_en[0], inc_en[6], inc_en[15:11],
                           clr_en[0], clr_en[6], clr_en[15:11]};

  always_comb begin
    w_bus = '0;
    case (src_e'(read_en))
      SRC_PC:  w_bus = r_pc;
      SRC_AR:  w_bus = r_ar;
      SRC_IR:  w_bus = r_ir;
      SRC_AC:  w_bus = r_ac;
      SRC_R:   w_bus = r_r;
      SRC_R1:  w_bus = r_r1;
      SRC_R2:  w_bus = r_r2;
      SRC_R3:  w_bus = r_r3;
      SRC_R4:  w_bus = r_r4;
      SRC_DM:  w_bus = dm_rdata;
      SRC_IM:  w_bus = im_rdata;
      default: w_bus = '0;
    endcase
  end

  assign w_bus_active = (read_en != 4'd0);
  // Live bus for same-cycle moves, latched value for the write half of a split transfer
  assign w_wd    = w_bus_active ? w_bus : r_bus_latch;
  assign w_ac_wd = write_en[WB_AC_ALU] ? w_alu_y : w_wd;

  datapath_alu #(.DW(DW)) u_alu (
    .i_a  (r_ac),
    .i_b  (r_r),
    .i_op (alu_op),
    .o_y  (w_alu_y)
  );

  // clr beats write beats inc; inc wraps naturally at 2^DW
  function automatic logic [DW-1:0] reg_next(input logic [DW-1:0] cur,
                                             input logic clr, input logic wr,
                                             input logic inc,
                                             input logic [DW-1:0] wd);
    if (clr)      return '0;
    else if (wr)  return wd;
    else if (inc) return cur + 1'b1;
    else          return cur;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_ar        <= '0;
      r_ir        <= '0;
      r_ac        <= '0;
      r_r         <= '0;
      r_r1        <= '0;
      r_r2        <= '0;
      r_r3        <= '0;
      r_r4        <= '0;
      r_bus_latch <= '0;
      r_dm_we     <= 1'b0;
      r_dm_wdata  <= '0;
    end else begin
      if (w_bus_active) r_bus_latch <= w_bus;
      r_pc <= reg_next(r_pc, clr_en[WB_PC], write_en[WB_PC], inc_en[WB_PC], w_wd);
      r_ar <= reg_next(r_ar, clr_en[WB_AR], write_en[WB_AR], inc_en[WB_AR], w_wd);
      r_ir <= reg_next(r_ir, clr_en[WB_IR], write_en[WB_IR], inc_en[WB_IR], w_wd);
      r_ac <= reg_next(r_ac, clr_en[WB_AC], write_en[WB_AC], inc_en[WB_AC], w_ac_wd);
      r_r  <= reg_next(r_r,  clr_en[WB_R],  write_en[WB_R],  inc_en[WB_R],  w_wd);
      r_r1 <= reg_next(r_r1, clr_en[WB_R1], write_en[WB_R1], inc_en[WB_R1], w_wd);
      r_r2 <= reg_next(r_r2, clr_en[WB_R2], write_en[WB_R2], inc_en[WB_R2], w_wd);
      r_r3 <= reg_next(r_r3, clr_en[WB_R3], write_en[WB_R3], inc_en[WB_R3], w_wd);
      r_r4 <= reg_next(r_r4, clr_en[WB_R4], write_en[WB_R4], inc_en[WB_R4], w_wd);
      // Strobe and data registered together; DM captures on the following edge
      r_dm_we <= write_en[WB_DM];
      if (write_en[WB_DM]) r_dm_wdata <= r_ac;
    end
  end

  assign im_addr     = r_pc;
  assign dm_addr     = r_ar;
  assign dm_we       = r_dm_we;
  assign dm_wdata    = r_dm_wdata;
  assign instruction = r_ir[IW-1:0];
  assign z           = {15'b0, (r_ac == '0)};

endmodule

// File: tb/tb_datapath_bus.sv
module tb_datapath_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  read_en  = '0;
  logic [15:0] write_en = '0;
  logic [15:0] inc_en   = '0;
  logic [15:0] clr_en   = '0;
  logic [2:0]  alu_op   = '0;
  logic [15:0] im_addr, dm_addr, dm_wdata;
  logic [15:0] im_rdata = '0;
  logic [15:0] dm_rdata = '0;
  logic        dm_we;
  logic [5:0]  instruction;
  logic [15:0] z;

  int n_chk  = 0;
  int n_fail = 0;

  datapath_bus dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
    .inc_en(inc_en), .clr_en(clr_en), .alu_op(alu_op),
    .im_addr(im_addr), .im_rdata(im_rdata), .dm_addr(dm_addr),
    .dm_rdata(dm_rdata), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .instruction(instruction), .z(z)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] b(input int i);
    logic [15:0] one;
    one = 16'd1;
    return one << i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, pass the edge, sample 1 time unit later, return to idle
  task automatic cyc(input logic [3:0] re, input logic [15:0] we,
                     input logic [15:0] ie, input logic [15:0] ce,
                     input logic [2:0] op);
    read_en = re; write_en = we; inc_en = ie; clr_en = ce; alu_op = op;
    @(posedge clk); #1;
    read_en = '0; write_en = '0; inc_en = '0; clr_en = '0; alu_op = '0;
  endtask

  // Same-cycle move from DM data into the registers selected by we
  task automatic load(input logic [15:0] val, input logic [15:0] we);
    dm_rdata = val;
    cyc(4'd12, we, 16'h0, 16'h0, 3'd0);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_pc", im_addr, 16'h0000);
    check("rst_ar", dm_addr, 16'h0000);
    check("rst_instr", instruction, 6'h00);
    check("rst_z", z, 16'h0001);
    check("rst_dmwe", dm_we, 1'b0);
    check("rst_latch", dut.r_bus_latch, 16'h0000);

    // Split IM -> IR transfer
    im_rdata = 16'h0013;
    cyc(4'd13, 16'h0, 16'h0, 16'h0, 3'd0);
    im_rdata = 16'hBEEF;
    cyc(4'd0, b(3), 16'h0, 16'h0, 3'd0);
    check("ir_val", dut.r_ir, 16'h0013);
    check("instr", instruction, 6'h13);

    // AC = 0x0040, split AC -> AR, then DM store
    load(16'h0040, b(4));
    check("ac_load", dut.r_ac, 16'h0040);
    cyc(4'd5, 16'h0, 16'h0, 16'h0, 3'd0);
    cyc(4'd0, b(2), 16'h0, 16'h0, 3'd0);
    check("dm_addr", dm_addr, 16'h0040);
    cyc(4'd0, b(11), 16'h0, 16'h0, 3'd0);
    check("dmwe_hi", dm_we, 1'b1);
    check("dm_wdata", dm_wdata, 16'h0040);
    cyc(4'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    check("dmwe_lo", dm_we, 1'b0);

    // sub 5-7
    load(16'h0005, b(4));
    load(16'h0007, b(5));
    cyc(4'd0, b(12) | b(4), 16'h0, 16'h0, 3'd2);
    check("sub_ac", dut.r_ac, 16'hFFFE);
    check("sub_z", z, 16'h0000);
    // add 5+FFFB
    load(16'hFFFB, b(5));
    load(16'h0005, b(4));
    cyc(4'd0, b(12) | b(4), 16'h0, 16'h0, 3'd1);
    check("add_ac", dut.r_ac, 16'h0000);
    check("add_z", z, 16'h0001);

    // lshift with zero fill, dropping the MSB
    load(16'h8001, b(4));
    cyc(4'd0, b(12) | b(4), 16'h0, 16'h0, 3'd4);
    check("lsh_ac", dut.r_ac, 16'h0002);
    // op 0 and op 6 pass A
    cyc(4'd0, b(12) | b(4), 16'h0, 16'h0, 3'd0);
    check("op0_ac", dut.r_ac, 16'h0002);
    cyc(4'd0, b(12) | b(4), 16'h0, 16'h0, 3'd6);
    check("op6_ac", dut.r_ac, 16'h0002);
    // bit12 without bit4
    cyc(4'd0, b(12), 16'h0, 16'h0, 3'd1);
    check("b12_only", dut.r_ac, 16'h0002);

    // PC wrap
    load(16'hFFFF, b(1));
    check("pc_load", im_addr, 16'hFFFF);
    cyc(4'd0, 16'h0, b(1), 16'h0, 3'd0);
    check("pc_wrap", im_addr, 16'h0000);

    // Priority on AC
    dm_rdata = 16'h1234;
    cyc(4'd12, b(4), b(4), b(4), 3'd0);
    check("clr_prio", dut.r_ac, 16'h0000);
    dm_rdata = 16'h0020;
    cyc(4'd12, b(4), b(4), 16'h0, 3'd0);
    check("wr_prio", dut.r_ac, 16'h0020);
    cyc(4'd0, 16'h0, b(4), 16'h0, 3'd0);
    check("inc_ac", dut.r_ac, 16'h0021);

    // Unmapped bits do nothing
    dm_rdata = 16'h7777;
    cyc(4'd12, b(0) | b(6) | b(13) | b(14) | b(15),
        b(0) | b(6) | b(13), b(0) | b(6) | b(14), 3'd0);
    check("unmapped", dut.r_ac, 16'h0021);
    // Unmapped source drives 0
    cyc(4'd3, b(4), 16'h0, 16'h0, 3'd0);
    check("src_none", dut.r_ac, 16'h0000);

    // Multiply
    load(16'h0100, b(4) | b(5));
    cyc(4'd0, b(12) | b(4), 16'h0, 16'h0, 3'd3);
`ifdef DP_ALU_MULT_EN
    check("mult_big", dut.r_ac, 16'h0000);
`else
    check("mult_big", dut.r_ac, 16'h0100);
`endif
    load(16'h0003, b(4));
    load(16'h0005, b(5));
    cyc(4'd0, b(12) | b(4), 16'h0, 16'h0, 3'd3);
`ifdef DP_ALU_MULT_EN
    check("mult_small", dut.r_ac, 16'h000F);
`else
    check("mult_small", dut.r_ac, 16'h0003);
`endif

    // Split transfer into R1, then multi-destination from the latch
    dm_rdata = 16'hABCD;
    cyc(4'd12, 16'h0, 16'h0, 16'h0, 3'd0);
    dm_rdata = 16'h0000;
    cyc(4'd0, b(10), 16'h0, 16'h0, 3'd0);
    check("r1_split", dut.r_r1, 16'hABCD);
    cyc(4'd0, b(7) | b(8) | b(9), 16'h0, 16'h0, 3'd0);
    check("multi_r2", dut.r_r2, 16'hABCD);
    check("multi_r3", dut.r_r3, 16'hABCD);
    check("multi_r4", dut.r_r4, 16'hABCD);
    // Same-cycle move R3 -> AC
    cyc(4'd9, b(4), 16'h0, 16'h0, 3'd0);
    check("r3_to_ac", dut.r_ac, 16'hABCD);

    // Reset between read and write halves of a DM load
    dm_rdata = 16'h5555;
    cyc(4'd12, 16'h0, 16'h0, 16'h0, 3'd0);
    rst = 1'b1;
    cyc(4'd0, b(4) | b(11), 16'h0, 16'h0, 3'd0);
    rst = 1'b0;
    check("mid_ac", dut.r_ac, 16'h0000);
    check("mid_latch", dut.r_bus_latch, 16'h0000);
    check("mid_regs", {dut.r_pc | dut.r_ar | dut.r_ir | dut.r_r,
                       dut.r_r1 | dut.r_r2 | dut.r_r3 | dut.r_r4}, 32'h0);
    check("mid_dmwe", dm_we, 1'b0);
    cyc(4'd0, b(4), 16'h0, 16'h0, 3'd0);
    check("post_ac", dut.r_ac, 16'h0000);
    check("post_z", z, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
